// File: rtl/sh7034_ubc_mc_pkg.sv
// Shared definitions for the SH7034 multi-channel user break controller:
// register map, field layouts, init constants and byte-merge helpers.
package sh7034_ubc_mc_pkg;

  localparam logic [27:0] UBC_BASE      = 28'h5FFFF90;
  localparam logic [27:0] UBC_BRCR_ADDR = 28'h5FFFFD0;
  localparam logic [27:0] UBC_LAST_ADDR = 28'h5FFFFD3;
  localparam logic [15:0] BBR_RD_MASK   = 16'h00FF;
  localparam logic [15:0] BRCR_RD_MASK  = 16'h0F0F;
  localparam logic [31:0] REG_INIT      = 32'h0000_0000;

  typedef enum logic [1:0] {
    REG_BAR  = 2'd0,
    REG_BAMR = 2'd1,
    REG_BBR  = 2'd2,
    REG_RSV  = 2'd3
  } ch_reg_e;

  typedef struct packed {
    logic [1:0] cd;
    logic [1:0] id;
    logic [1:0] rw;
    logic [1:0] sz;
  } bbr_t;

  typedef struct packed {
    logic [3:0] rsv_hi;
    logic [3:0] en;
    logic [3:0] rsv_lo;
    logic [3:0] cmf;
  } brcr_t;

  localparam bbr_t  BBR_INIT  = bbr_t'(8'h00);
  localparam brcr_t BRCR_INIT = brcr_t'(16'h0000);

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  function automatic logic [31:0] addr_mask(input int w);
    logic [31:0] m;
    for (int i = 0; i < 32; i++) begin
      m[i] = (i < w) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/sh7034_ubc_cmp.sv
// One break channel: BAR/BAMR/BBR storage and the registered bus-cycle
// comparison feeding the channel's flag.
module sh7034_ubc_cmp
  import sh7034_ubc_mc_pkg::*;
#(
  parameter int ADDR_W  = 28,
  parameter bit DISABLE = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE_R,
  input  logic              RES_N,
  input  logic              wr_bar,
  input  logic              wr_bamr,
  input  logic              wr_bbr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        be,
  input  logic              en,
  input  logic [ADDR_W-1:0] mon_a,
  input  logic              mon_valid,
  input  logic              mon_we,
  input  logic              mon_if,
  input  logic              mon_dma,
  input  logic [1:0]        mon_sz,
  output logic [31:0]       bar_rd,
  output logic [31:0]       bamr_rd,
  output logic [31:0]       bbr_rd,
  output logic              hit
);

  localparam logic [31:0] A_MASK = addr_mask(ADDR_W);

  logic [31:0]       bar_r;
  logic [31:0]       bamr_r;
  bbr_t              bbr_r;
  logic              hit_r;
  logic [ADDR_W-1:0] diff_s;
  logic              match_s;

  // Per-cycle comparison; a 00 in CD/ID/RW leaves no accepted case.
  always_comb begin
    diff_s  = (mon_a ^ bar_r[ADDR_W-1:0]) & ~bamr_r[ADDR_W-1:0];
    match_s = mon_valid && en && !DISABLE
              && (diff_s == {ADDR_W{1'b0}})
              && (mon_dma ? bbr_r.cd[1] : bbr_r.cd[0])
              && (mon_if  ? bbr_r.id[0] : bbr_r.id[1])
              && (mon_we  ? bbr_r.rw[1] : bbr_r.rw[0])
              && ((bbr_r.sz == 2'b00) || (bbr_r.sz == mon_sz));
  end

  // Channel registers and the hit stage of the match pipeline.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bar_r  <= REG_INIT;
      bamr_r <= REG_INIT;
      bbr_r  <= BBR_INIT;
      hit_r  <= 1'b0;
    end else if (!RES_N) begin
      bar_r  <= REG_INIT;
      bamr_r <= REG_INIT;
      bbr_r  <= BBR_INIT;
      hit_r  <= 1'b0;
    end else if (CE_R) begin
      if (wr_bar)         bar_r  <= merge_be(bar_r, wdata, be) & A_MASK;
      if (wr_bamr)        bamr_r <= merge_be(bamr_r, wdata, be) & A_MASK;
      if (wr_bbr && be[2]) bbr_r <= bbr_t'(wdata[23:16]);
      hit_r <= match_s;
    end
  end

  assign bar_rd  = bar_r;
  assign bamr_rd = bamr_r;
  assign bbr_rd  = {16'({8'h00, bbr_r}) & BBR_RD_MASK, 16'h0000};
  assign hit     = hit_r;

endmodule

// File: rtl/sh7034_ubc_mc.sv
// SH7034 multi-channel user break controller: register decode, BRCR
// flags/enables, read capture and the level break interrupt.
module sh7034_ubc_mc
  import sh7034_ubc_mc_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 28,
  parameter bit DISABLE = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE_R,
  input  logic              CE_F,
  input  logic              RES_N,
  input  logic [27:0]       IBUS_A,
  input  logic [31:0]       IBUS_DI,
  output logic [31:0]       IBUS_DO,
  input  logic [3:0]        IBUS_BA,
  input  logic              IBUS_WE,
  input  logic              IBUS_REQ,
  output logic              IBUS_BUSY,
  output logic              IBUS_ACT,
  input  logic [ADDR_W-1:0] MON_A,
  input  logic              MON_VALID,
  input  logic              MON_WE,
  input  logic              MON_IF,
  input  logic              MON_DMA,
  input  logic [1:0]        MON_SZ,
  output logic              IRQ
);

  localparam logic [3:0] CH_MASK = 4'((5'd1 << NUM_CH) - 5'd1);

  logic        reg_sel_s;
  logic        brcr_sel_s;
  logic        chan_sel_s;
  logic        wr_s;
  logic [3:0]  blk_s;
  ch_reg_e     reg_idx_s;
  logic [31:0] bar_rd_s  [4];
  logic [31:0] bamr_rd_s [4];
  logic [31:0] bbr_rd_s  [4];
  logic [3:0]  hit_vec_s;
  logic [3:0]  cmf_clr_s;
  logic [3:0]  cmf_nxt_s;
  logic [3:0]  en_nxt_s;
  logic [3:0]  cmf_r;
  logic [3:0]  en_r;
  logic [31:0] rd_data_s;
  logic [31:0] do_r;
  logic        irq_r;
  brcr_t       brcr_s;

  assign reg_sel_s  = (IBUS_A >= UBC_BASE) && (IBUS_A <= UBC_LAST_ADDR);
  assign blk_s      = IBUS_A[7:4] - 4'h9;
  assign reg_idx_s  = ch_reg_e'(IBUS_A[3:2]);
  assign brcr_sel_s = reg_sel_s && (IBUS_A[27:2] == UBC_BRCR_ADDR[27:2]);
  assign chan_sel_s = reg_sel_s && (blk_s < 4'(NUM_CH));
  assign wr_s       = reg_sel_s && IBUS_REQ && IBUS_WE && !DISABLE;

  for (genvar n = 0; n < 4; n++) begin : g_ch
    if (n < NUM_CH) begin : g_on
      logic sel_s;
      assign sel_s = wr_s && chan_sel_s && (blk_s[1:0] == 2'(n));
      sh7034_ubc_cmp #(.ADDR_W(ADDR_W), .DISABLE(DISABLE)) u_cmp (
        .CLK       (CLK),
        .RST       (RST),
        .CE_R      (CE_R),
        .RES_N     (RES_N),
        .wr_bar    (sel_s && (reg_idx_s == REG_BAR)),
        .wr_bamr   (sel_s && (reg_idx_s == REG_BAMR)),
        .wr_bbr    (sel_s && (reg_idx_s == REG_BBR)),
        .wdata     (IBUS_DI),
        .be        (IBUS_BA),
        .en        (en_r[n]),
        .mon_a     (MON_A),
        .mon_valid (MON_VALID),
        .mon_we    (MON_WE),
        .mon_if    (MON_IF),
        .mon_dma   (MON_DMA),
        .mon_sz    (MON_SZ),
        .bar_rd    (bar_rd_s[n]),
        .bamr_rd   (bamr_rd_s[n]),
        .bbr_rd    (bbr_rd_s[n]),
        .hit       (hit_vec_s[n])
      );
    end else begin : g_off
      assign bar_rd_s[n]  = REG_INIT;
      assign bamr_rd_s[n] = REG_INIT;
      assign bbr_rd_s[n]  = REG_INIT;
      assign hit_vec_s[n] = 1'b0;
    end
  end

  // Flag/enable next state; a hit landing with a write-clear keeps the flag.
  always_comb begin
    if (wr_s && brcr_sel_s && IBUS_BA[2]) begin
      cmf_clr_s = ~IBUS_DI[19:16];
    end else begin
      cmf_clr_s = 4'h0;
    end
    if (wr_s && brcr_sel_s && IBUS_BA[3]) begin
      en_nxt_s = IBUS_DI[27:24] & CH_MASK;
    end else begin
      en_nxt_s = en_r;
    end
    cmf_nxt_s = ((cmf_r & ~cmf_clr_s) | hit_vec_s) & CH_MASK;
  end

  // Read data selection for the addressed register.
  always_comb begin
    brcr_s     = BRCR_INIT;
    brcr_s.en  = en_r;
    brcr_s.cmf = cmf_r;
    rd_data_s  = REG_INIT;
    if (DISABLE) begin
      rd_data_s = REG_INIT;
    end else if (brcr_sel_s) begin
      rd_data_s = {16'(brcr_s) & BRCR_RD_MASK, 16'h0000};
    end else if (chan_sel_s) begin
      case (reg_idx_s)
        REG_BAR:  rd_data_s = bar_rd_s[blk_s[1:0]];
        REG_BAMR: rd_data_s = bamr_rd_s[blk_s[1:0]];
        REG_BBR:  rd_data_s = bbr_rd_s[blk_s[1:0]];
        default:  rd_data_s = REG_INIT;
      endcase
    end else begin
      rd_data_s = REG_INIT;
    end
  end

  // BRCR state, registered interrupt and falling-phase read capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmf_r <= 4'h0;
      en_r  <= 4'h0;
      irq_r <= 1'b0;
      do_r  <= REG_INIT;
    end else if (!RES_N) begin
      cmf_r <= 4'h0;
      en_r  <= 4'h0;
      irq_r <= 1'b0;
      do_r  <= REG_INIT;
    end else begin
      if (CE_R) begin
        cmf_r <= cmf_nxt_s;
        en_r  <= en_nxt_s;
        irq_r <= (|(cmf_nxt_s & en_nxt_s)) && !DISABLE;
      end
      if (CE_F && reg_sel_s && IBUS_REQ && !IBUS_WE) begin
        do_r <= rd_data_s;
      end
    end
  end

  assign IBUS_DO   = reg_sel_s ? do_r : REG_INIT;
  assign IBUS_BUSY = 1'b0;
  assign IBUS_ACT  = reg_sel_s;
  assign IRQ       = irq_r;

endmodule

// File: tb/tb_sh7034_ubc_mc.sv
// Directed bench for sh7034_ubc_mc: register access, match pipeline,
// flag clear priority, enable gating, clock enable hold and resets.
module tb_sh7034_ubc_mc;

  localparam logic [27:0] BAR0  = 28'h5FFFF90;
  localparam logic [27:0] BAMR0 = 28'h5FFFF94;
  localparam logic [27:0] BBR0  = 28'h5FFFF98;
  localparam logic [27:0] BAR1  = 28'h5FFFFA0;
  localparam logic [27:0] BAMR1 = 28'h5FFFFA4;
  localparam logic [27:0] BBR1  = 28'h5FFFFA8;
  localparam logic [27:0] BRCR  = 28'h5FFFFD0;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CE_R = 1'b1;
  logic        CE_F = 1'b1;
  logic        RES_N = 1'b1;
  logic [27:0] IBUS_A = 28'h0;
  logic [31:0] IBUS_DI = 32'h0;
  logic [31:0] IBUS_DO;
  logic [3:0]  IBUS_BA = 4'h0;
  logic        IBUS_WE = 1'b0;
  logic        IBUS_REQ = 1'b0;
  logic        IBUS_BUSY;
  logic        IBUS_ACT;
  logic [27:0] MON_A = 28'h0;
  logic        MON_VALID = 1'b0;
  logic        MON_WE = 1'b0;
  logic        MON_IF = 1'b0;
  logic        MON_DMA = 1'b0;
  logic [1:0]  MON_SZ = 2'b00;
  logic        IRQ;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] rd;

  sh7034_ubc_mc #(.NUM_CH(2), .ADDR_W(28), .DISABLE(1'b0)) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
    .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_DO(IBUS_DO), .IBUS_BA(IBUS_BA),
    .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT),
    .MON_A(MON_A), .MON_VALID(MON_VALID), .MON_WE(MON_WE), .MON_IF(MON_IF),
    .MON_DMA(MON_DMA), .MON_SZ(MON_SZ), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_wr(input logic [27:0] a, input logic [31:0] d, input logic [3:0] be);
    IBUS_A = a; IBUS_DI = d; IBUS_BA = be; IBUS_WE = 1'b1; IBUS_REQ = 1'b1;
    tick();
    IBUS_WE = 1'b0; IBUS_REQ = 1'b0;
  endtask

  task automatic bus_rd(input logic [27:0] a, output logic [31:0] d);
    IBUS_A = a; IBUS_WE = 1'b0; IBUS_REQ = 1'b1;
    tick();
    d = IBUS_DO;
    IBUS_REQ = 1'b0;
  endtask

  task automatic mon_set(input logic [27:0] a, input logic we, input logic ifc,
                         input logic dma, input logic [1:0] sz);
    MON_A = a; MON_WE = we; MON_IF = ifc; MON_DMA = dma; MON_SZ = sz; MON_VALID = 1'b1;
  endtask

  task automatic setup_ch0();
    bus_wr(BAR0, 32'h0600_1200, 4'hF);
    bus_wr(BAMR0, 32'h0000_00FF, 4'hF);
    bus_wr(BBR0, 32'h0055_0000, 4'b1100);
    bus_wr(BRCR, 32'h0100_0000, 4'b1000);
  endtask

  logic [27:0] rej_a  [3] = '{28'h60012A4, 28'h60012A4, 28'h6001300};
  logic        rej_d  [3] = '{1'b1, 1'b0, 1'b0};
  logic [1:0]  rej_sz [3] = '{2'b01, 2'b11, 2'b01};

  initial begin
    tick(); tick();
    check("irq_in_reset", {31'h0, IRQ}, 32'h0);
    RST = 1'b0;
    tick();
    check("busy_const", {31'h0, IBUS_BUSY}, 32'h0);
    bus_rd(BRCR, rd); check("rst_brcr", rd, 32'h0);
    bus_rd(BAR0, rd); check("rst_bar0", rd, 32'h0);

    // Register round trip, byte enables and decode window
    bus_wr(BAR0, 32'h0600_1234, 4'hF);
    bus_rd(BAR0, rd); check("bar0_rt", rd, 32'h0600_1234);
    bus_wr(BAR0, 32'hAABB_CCDD, 4'b0101);
    bus_rd(BAR0, rd); check("bar0_be", rd, 32'h06BB_12DD);
    bus_wr(BAMR0, 32'hFFFF_FFFF, 4'hF);
    bus_rd(BAMR0, rd); check("bamr0_width", rd, 32'h0FFF_FFFF);
    bus_wr(BBR0, 32'hFFFF_0000, 4'b1100);
    bus_rd(BBR0, rd); check("bbr0_mask", rd, 32'h00FF_0000);
    bus_wr(28'h5FFFF9C, 32'hFFFF_FFFF, 4'hF);
    bus_rd(28'h5FFFF9C, rd); check("unused_off", rd, 32'h0);
    bus_rd(BAR0, rd);
    IBUS_A = 28'h5FFFFD4; #1;
    check("act_above", {31'h0, IBUS_ACT}, 32'h0);
    check("do_desel", IBUS_DO, 32'h0);
    IBUS_A = 28'h5FFFFD3; #1; check("act_last", {31'h0, IBUS_ACT}, 32'h1);
    IBUS_A = 28'h5FFFF8F; #1; check("act_below", {31'h0, IBUS_ACT}, 32'h0);

    // Masked match with two-edge latency
    setup_ch0();
    mon_set(28'h60012A4, 1'b0, 1'b1, 1'b0, 2'b01);
    tick();
    MON_VALID = 1'b0;
    check("irq_lat1", {31'h0, IRQ}, 32'h0);
    tick();
    check("irq_lat2", {31'h0, IRQ}, 32'h1);
    bus_rd(BRCR, rd); check("cmf0_set", rd, 32'h0101_0000);
    bus_wr(BRCR, 32'h0100_0000, 4'b0100);
    check("irq_clr", {31'h0, IRQ}, 32'h0);

    // Condition rejects: DMA master, size, address outside mask
    for (int i = 0; i < 3; i++) begin
      mon_set(rej_a[i], 1'b0, 1'b1, rej_d[i], rej_sz[i]);
      tick();
      MON_VALID = 1'b0;
      tick();
      check($sformatf("rej%0d_irq", i), {31'h0, IRQ}, 32'h0);
      bus_rd(BRCR, rd); check($sformatf("rej%0d_brcr", i), rd, 32'h0100_0000);
    end

    // Two channels hit together; clear coinciding with a hit keeps the flag
    bus_wr(BAR1, 32'h0600_1200, 4'hF);
    bus_wr(BAMR1, 32'h0000_00FF, 4'hF);
    bus_wr(BBR1, 32'h00FC_0000, 4'b1100);
    bus_wr(BRCR, 32'h0300_0000, 4'b1000);
    mon_set(28'h60012A4, 1'b0, 1'b1, 1'b0, 2'b01);
    tick(); MON_VALID = 1'b0; tick();
    bus_rd(BRCR, rd); check("cmf_both", rd, 32'h0303_0000);
    mon_set(28'h60012A4, 1'b0, 1'b1, 1'b0, 2'b01);
    tick(); MON_VALID = 1'b0;
    bus_wr(BRCR, 32'h0302_0000, 4'b0100);
    bus_rd(BRCR, rd); check("set_wins", rd, 32'h0303_0000);
    bus_wr(BRCR, 32'h0302_0000, 4'b0100);
    bus_rd(BRCR, rd); check("cmf0_clr", rd, 32'h0302_0000);
    check("irq_ch1", {31'h0, IRQ}, 32'h1);

    // Enable gating keeps the flag
    bus_wr(BRCR, 32'h0100_0000, 4'b1000);
    check("irq_en_off", {31'h0, IRQ}, 32'h0);
    bus_rd(BRCR, rd); check("cmf1_kept", rd, 32'h0102_0000);

    // No CE_R: writes and matches do not land
    CE_R = 1'b0;
    mon_set(28'h60012A4, 1'b0, 1'b1, 1'b0, 2'b01);
    bus_wr(BAR0, 32'h1234_5678, 4'hF);
    MON_VALID = 1'b0;
    tick();
    bus_rd(BAR0, rd); check("ce_hold_bar", rd, 32'h0600_1200);
    CE_R = 1'b1;
    tick();
    bus_rd(BRCR, rd); check("ce_hold_brcr", rd, 32'h0102_0000);

    // Async reset between sample and flag edge
    bus_wr(BRCR, 32'h0100_0000, 4'b0100);
    mon_set(28'h60012A4, 1'b0, 1'b1, 1'b0, 2'b01);
    tick(); MON_VALID = 1'b0;
    RST = 1'b1; #1;
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    tick(); RST = 1'b0; tick(); tick();
    bus_rd(BRCR, rd); check("rst_nflag", rd, 32'h0);
    bus_rd(BAR0, rd); check("rst_bar0b", rd, 32'h0);

    // Soft reset at the flag edge
    setup_ch0();
    mon_set(28'h60012A4, 1'b0, 1'b1, 1'b0, 2'b01);
    tick(); MON_VALID = 1'b0;
    RES_N = 1'b0; tick(); RES_N = 1'b1; tick();
    check("resn_irq", {31'h0, IRQ}, 32'h0);
    bus_rd(BRCR, rd); check("resn_brcr", rd, 32'h0);
    bus_rd(BBR0, rd); check("resn_bbr0", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sh7034_ubc_mc.md
# sh7034_ubc_mc

Multi-channel user break controller for the SH7034 core. It holds per-channel break address, mask and condition registers on the internal peripheral bus. It snoops every CPU/DMA bus cycle and compares it against each enabled channel. On a match it sets a sticky per-channel flag and raises a level interrupt request to the interrupt controller. It replaces the register-only break controller; each channel behaves like a single SH7034 UBC, with NUM_CH independent comparators.

## Interface
- NUM_CH, 2, number of break channels, 1..4
- ADDR_W, 28, compared address width, 16..32
- DISABLE, 0, when 1: registers never written, reads return 0, no match, IRQ stuck 0
- CLK  in  1  system clock
- RST  in  1  reset, asynchronous, active-high
- CE_R  in  1  rising-phase clock enable: writes, match pipeline
- CE_F  in  1  falling-phase clock enable: read data capture
- RES_N  in  1  synchronous soft reset, active-low; same effect as RST
- IBUS_A  in  28  register address
- IBUS_DI  in  32  write data
- IBUS_DO  out  32  read data; 0 when not selected
- IBUS_BA  in  4  byte enables, [3] = bits 31:24
- IBUS_WE, IBUS_REQ  in  1  write strobe, request
- IBUS_BUSY  out  1  constant 0
- IBUS_ACT  out  1  high while address selects this block
- MON_A  in  ADDR_W  snooped bus-cycle address
- MON_VALID  in  1  snooped cycle valid (qualified by CE_R)
- MON_WE  in  1  1 = write
- MON_IF  in  1  1 = instruction fetch, 0 = data
- MON_DMA  in  1  1 = DMA master, 0 = CPU
- MON_SZ  in  2  01 byte, 10 word, 11 long
- IRQ  out  1  break interrupt request, level

## Operation
- Register map: channel n base = 0x5FFFF90 + 0x10·n.
  - BAR: +0, 32-bit.
  - BAMR: +4, 32-bit; 1 = bit ignored.
  - BBR: +8, upper halfword.
- BRCR: 0x5FFFFD0, upper halfword. Bits [NUM_CH-1:0] are the flags CMF; bits [NUM_CH+7:8] are the enables EN.
- IBUS_ACT = 1 for addresses from the first base through 0x5FFFFD3.
- Writes honour byte enables per byte. Bits above ADDR_W in BAR/BAMR read 0.
- BBR fields:
  - CD[7:6]: 01 CPU, 10 DMA, 11 both.
  - ID[5:4]: 01 fetch, 10 data, 11 both.
  - RW[3:2]: 01 read, 10 write, 11 both.
  - SZ[1:0]: 00 any, else exact size.
  - Other bits read 0.
  - A value of 00 in CD, ID or RW disables that channel.
- Channel match requires all of the following:
  - MON_VALID.
  - EN[n].
  - ((MON_A ^ BAR) & ~BAMR) == 0 on ADDR_W bits.
  - The CD, ID, RW and SZ conditions are satisfied.
- CMF[n] is sticky.
  - Writing 0 to a CMF bit with its byte enabled clears it; writing 1 has no effect.
  - If a set and a clear land on the same CE_R edge, the set wins.
- IRQ = OR over n of (CMF[n] & EN[n]).
- Unused register offsets read 0 and ignore writes.
- Reset values (RST or RES_N low): all registers 0, REG_DO 0, pipeline cleared, IRQ 0.

## Timing
- Write: takes effect on the CE_R edge where REG_SEL & IBUS_REQ & IBUS_WE.
- Read: REG_DO is captured on the CE_F edge where REG_SEL & IBUS_REQ & !IBUS_WE. IBUS_DO = REG_SEL ? REG_DO : 0.
- Match pipeline, in CE_R edges:
  - Edge k: monitor inputs are sampled and the per-channel comparisons are registered into a hit vector.
  - Edge k+1: the hit vector ORs into CMF.
  - IRQ is high after edge k+1, 2 CE_R edges after the sampled cycle.
- Register writes at edge k affect comparisons sampled at edge k+1 onward.
- Consecutive valid cycles are matched back-to-back, with no gaps.
- Clearing EN[n] drops that channel's IRQ contribution immediately after the write edge. CMF[n] is retained.
- A reset mid-pipeline discards the pending hit; no flag is set afterwards.
- Without CE_R, all state holds.

## Structure
- Shared package SH7034_PKG gains:
  - BBR_t as a packed struct (CD/ID/RW/SZ).
  - BRCR_t.
  - UBC_BASE and UBC_BRCR_ADDR.
  - Read and write masks.
  - NUM_CH-independent init constants.
- Sub-module sh7034_ubc_cmp (one per channel, generate loop): holds the channel's registers and produces the registered hit.

## Test plan
- Read/write round trip:
  - Write BAR0 = 0x0600_1234 (byte enables 1111), read back -> 0x0600_1234.
  - Write BBR0 = 0xFFFF -> reads 0x00FF_0000 in the upper halfword position, i.e. 0x00FF.
  - Offset 0x5FFFF9C reads 0.
- Masked match:
  - Setup: BAR0 = 0x0600_1200, BAMR0 = 0x0000_00FF, BBR0 = 0x0055 (CPU, fetch, read, byte), EN0 = 1.
  - MON_A = 0x0600_12A4 CPU fetch read byte -> IRQ = 1 two CE_R edges later, BRCR reads CMF0 = 1.
- Condition reject: same setup with MON_DMA = 1, or SZ = 11, or MON_A = 0x0600_1300 -> no flag, IRQ stays 0.
- Multi-channel and clear:
  - Ch0 and ch1 both match in the same cycle -> CMF = 0b11.
  - Write 0 to CMF0 in the same edge as a new ch0 hit -> CMF0 stays 1.
  - Next write-clear -> CMF0 = 0, IRQ stays 1 through ch1.
- Enable gating: CMF1 = 1, write EN1 = 0 -> IRQ drops the next cycle, CMF1 still reads 1.
- Reset:
  - RST asserted between the sample edge and the flag edge -> all registers 0, IRQ 0, no flag after release.
  - RES_N low gives the same result.
